mod_reduce_arbiter: RTL and testbench

MOD_REDUCE_ARBITER -- requirements
Module: mod_reduce_arbiter

---
 rtl/mod_reduce_arbiter.sv | 104 ++++++++++
 tb/tb_mod_reduce_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mod_reduce_arbiter.sv
// Round-robin arbiter in front of one shared modular reducer. The reduced result
// lands in a single output register that has valid/ready handshaking.
module mod_reduce_arbiter #(
    parameter int W_BITS_L = 12,
    parameter int Q_MOD_L  = 3329,
    parameter int NREQ     = 4,
    parameter int W        = W_BITS_L,
    parameter int WW       = 2 * W_BITS_L
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic signed [WW-1:0]       req_val [NREQ],
    output logic [NREQ-1:0]            req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_mod,
    output logic [$clog2(NREQ)-1:0]    out_id,
    output logic [31:0]                done_cnt
);
    localparam int PW = $clog2(NREQ);
    localparam logic signed [WW:0] QS = (WW + 1)'(Q_MOD_L);

    logic                 r_out_valid;
    logic [W-1:0]         r_out_mod;
    logic [PW-1:0]        r_out_id;
    logic [PW-1:0]        r_rr_ptr;
    logic [31:0]          r_done_cnt;

    logic                 w_slot_free;
    logic                 w_out_hs;
    logic                 w_grant_any;
    logic [PW-1:0]        w_grant_id;
    logic [NREQ-1:0]      w_grant_oh;
    logic signed [WW-1:0] w_sel_val;
    logic [W-1:0]         w_red;

    // One extra bit keeps the sign of the operand and makes Q positive in signed space.
    function automatic logic [W-1:0] reduce(input logic signed [WW-1:0] x);
        logic signed [WW:0] xe;
        logic signed [WW:0] r;
        xe = {x[WW-1], x};
        r  = xe % QS;
        if (r < 0)
            r = r + QS;
        return r[W-1:0];
    endfunction

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_out_hs    = r_out_valid && out_ready;

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_grant_oh  = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!w_grant_any && req_valid[idx]) begin
                w_grant_any = 1'b1;
                w_grant_id  = idx[PW-1:0];
            end
        end
        // rst gating keeps grants low during reset even though the slot reads free
        if (!w_slot_free || rst) begin
            w_grant_any = 1'b0;
            w_grant_id  = '0;
        end
        if (w_grant_any)
            w_grant_oh[w_grant_id] = 1'b1;
    end

    assign w_sel_val = req_val[w_grant_id];
    assign w_red     = reduce(w_sel_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_mod   <= '0;
            r_out_id    <= '0;
            r_rr_ptr    <= '0;
            r_done_cnt  <= '0;
        end else begin
            if (w_out_hs)
                r_done_cnt <= r_done_cnt + 32'd1;
            if (w_grant_any) begin
                r_out_valid <= 1'b1;
                r_out_mod   <= w_red;
                r_out_id    <= w_grant_id;
                r_rr_ptr    <= (w_grant_id == PW'(NREQ - 1)) ? '0 : w_grant_id + PW'(1);
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign req_ready = w_grant_oh;
    assign out_valid = r_out_valid;
    assign out_mod   = r_out_mod;
    assign out_id    = r_out_id;
    assign done_cnt  = r_done_cnt;
endmodule

// File: tb/tb_mod_reduce_arbiter.sv
// Directed bench for mod_reduce_arbiter (NREQ=4, W=12, WW=24, Q=3329).
module tb_mod_reduce_arbiter;
    localparam int Q = 3329;

    logic               clk;
    logic               rst;
    logic [3:0]         req_valid;
    logic signed [23:0] req_val [4];
    logic [3:0]         req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [11:0]        out_mod;
    logic [1:0]         out_id;
    logic [31:0]        done_cnt;

    int checks = 0;
    int errors = 0;

    mod_reduce_arbiter #(.W_BITS_L(12), .Q_MOD_L(Q), .NREQ(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_val(req_val),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_mod(out_mod), .out_id(out_id), .done_cnt(done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; req_valid = 4'hF;
        for (int i = 0; i < 4; i++) req_val[i] = 24'sd5;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (out_mod !== 12'd0) begin errors++; $display("FAIL reset_mod got %0d exp 0", out_mod); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", out_id); end
        checks++; if (done_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", done_cnt); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        req_valid = 4'h0;
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_single();
        req_valid = 4'b0100; req_val[2] = -24'sd1; out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (out_valid !== 1'b1 || out_mod !== 12'(Q - 1) || out_id !== 2'd2)
            begin errors++; $display("FAIL single_out got v=%0b mod=%0d id=%0d exp v=1 mod=%0d id=2", out_valid, out_mod, out_id, Q - 1); end
        $display("txn single req=2 val=-1 mod=%0d", out_mod);
        step();
        checks++; if (out_valid !== 1'b0 || done_cnt !== 32'd1)
            begin errors++; $display("FAIL single_consume got v=%0b cnt=%0d exp v=0 cnt=1", out_valid, done_cnt); end
    endtask

    task automatic test_back_to_back();
        logic signed [23:0] vec [4];
        logic [11:0] exp_mod [4];
        vec = '{24'sd3329, 24'sd6663, -24'sd6658, 24'sd0};
        exp_mod = '{12'd0, 12'd5, 12'd0, 12'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001; req_val[0] = vec[i];
            #1;
            checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 0001", i, req_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_mod !== exp_mod[i] || out_id !== 2'd0)
                begin errors++; $display("FAIL b2b_out[%0d] got v=%0b mod=%0d id=%0d exp v=1 mod=%0d id=0", i, out_valid, out_mod, out_id, exp_mod[i]); end
            $display("txn b2b req=0 val=%0d mod=%0d", vec[i], out_mod);
        end
        req_valid = 4'b0000;
        step();
        checks++; if (out_valid !== 1'b0 || done_cnt !== 32'd5)
            begin errors++; $display("FAIL b2b_drain got v=%0b cnt=%0d exp v=0 cnt=5", out_valid, done_cnt); end
    endtask

    task automatic test_round_robin();
        int order [6];
        logic [11:0] exp_mod [4];
        order = '{0, 1, 2, 3, 0, 1};
        exp_mod = '{12'd1, 12'd3326, 12'd3328, 12'd0};
        // Single grant to requester 3 brings the pointer back to 0.
        req_valid = 4'b1000; req_val[3] = 24'sd100; out_ready = 1'b1;
        step();
        checks++; if (out_mod !== 12'd100 || out_id !== 2'd3)
            begin errors++; $display("FAIL rr_prime got mod=%0d id=%0d exp mod=100 id=3", out_mod, out_id); end
        req_valid = 4'b0000;
        step();
        req_val[0] = 24'sd9988; req_val[1] = -24'sd3; req_val[2] = 24'sd3328; req_val[3] = -24'sd3329;
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (req_ready !== (4'b0001 << order[i]))
                begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", i, req_ready, 4'b0001 << order[i]); end
            step();
            checks++; if (out_valid !== 1'b1 || out_id !== 2'(order[i]) || out_mod !== exp_mod[order[i]])
                begin errors++; $display("FAIL rr_out[%0d] got v=%0b id=%0d mod=%0d exp v=1 id=%0d mod=%0d", i, out_valid, out_id, out_mod, order[i], exp_mod[order[i]]); end
            $display("txn rr grant=%0d mod=%0d", out_id, out_mod);
        end
        req_valid = 4'b0000;
        step();
        checks++; if (done_cnt !== 32'd12) begin errors++; $display("FAIL rr_cnt got %0d exp 12", done_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; req_valid = 4'b0001; req_val[0] = -24'sd5;
        step();
        req_valid = 4'b1010; req_val[1] = 24'sd50; req_val[3] = 24'sd3332;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_mod !== 12'd3324 || out_id !== 2'd0)
                begin errors++; $display("FAIL bp_hold[%0d] got rdy=%b v=%0b mod=%0d id=%0d exp rdy=0000 v=1 mod=3324 id=0", i, req_ready, out_valid, out_mod, out_id); end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release got %b exp 0010", req_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_mod !== 12'd50 || done_cnt !== 32'd13)
            begin errors++; $display("FAIL bp_first got v=%0b id=%0d mod=%0d cnt=%0d exp v=1 id=1 mod=50 cnt=13", out_valid, out_id, out_mod, done_cnt); end
        $display("txn bp grant=1 mod=%0d", out_mod);
        req_valid = 4'b1000;
        step();
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd3 || out_mod !== 12'd3 || done_cnt !== 32'd14)
            begin errors++; $display("FAIL bp_second got v=%0b id=%0d mod=%0d cnt=%0d exp v=1 id=3 mod=3 cnt=14", out_valid, out_id, out_mod, done_cnt); end
        $display("txn bp grant=3 mod=%0d", out_mod);
        req_valid = 4'b0000;
        step();
        checks++; if (out_valid !== 1'b0 || done_cnt !== 32'd15)
            begin errors++; $display("FAIL bp_drain got v=%0b cnt=%0d exp v=0 cnt=15", out_valid, done_cnt); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; req_valid = 4'b0100; req_val[2] = 24'sd7;
        step();
        req_valid = 4'b1001; req_val[0] = 24'sd11; req_val[3] = 24'sd22;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got v=%0b exp 1", out_valid); end
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || done_cnt !== 32'd0 || req_ready !== 4'b0000 || out_mod !== 12'd0)
            begin errors++; $display("FAIL mid_async got v=%0b cnt=%0d rdy=%b mod=%0d exp v=0 cnt=0 rdy=0000 mod=0", out_valid, done_cnt, req_ready, out_mod); end
        rst = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr0 got %b exp 0001", req_ready); end
        step();
        checks++; if (out_id !== 2'd0 || out_mod !== 12'd11)
            begin errors++; $display("FAIL mid_g0 got id=%0d mod=%0d exp id=0 mod=11", out_id, out_mod); end
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_ready3 got %b exp 1000", req_ready); end
        step();
        checks++; if (out_id !== 2'd3 || out_mod !== 12'd22)
            begin errors++; $display("FAIL mid_g3 got id=%0d mod=%0d exp id=3 mod=22", out_id, out_mod); end
        $display("txn reset_mid grants 0 then 3");
        req_valid = 4'b0000;
        step();
        checks++; if (done_cnt !== 32'd2) begin errors++; $display("FAIL mid_cnt got %0d exp 2", done_cnt); end
    endtask

    task automatic test_wrap();
        force dut.r_done_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_done_cnt;
        #1;
        checks++; if (done_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_load got %h exp ffffffff", done_cnt); end
        out_ready = 1'b1; req_valid = 4'b0010; req_val[1] = 24'sd1;
        step();
        req_valid = 4'b0000;
        checks++; if (done_cnt !== 32'hFFFF_FFFF || out_valid !== 1'b1)
            begin errors++; $display("FAIL wrap_hold got cnt=%h v=%0b exp cnt=ffffffff v=1", done_cnt, out_valid); end
        step();
        checks++; if (done_cnt !== 32'd0) begin errors++; $display("FAIL wrap_zero got %h exp 00000000", done_cnt); end
        $display("txn wrap cnt=%h", done_cnt);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
